// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : md_issue_ctrl
// Brief   : Issue controller for a multiply/divide unit with hi/lo readback.
// Revision: 1.0
// ============================================================================
module md_issue_ctrl #(
  parameter int TMO = 80
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Op_Valid,
  input  logic [2:0]  Op_Code,
  input  logic [31:0] Op_A,
  input  logic [31:0] Op_B,
  output logic        Op_Ready,
  output logic        Stall,
  output logic        Rd_Valid,
  output logic [31:0] Rd_Data,
  output logic        DivZero,
  output logic        TimeoutErr,
  output logic        MUL_Start,
  output logic        MUL_SelMD,
  output logic        MUL_Sign,
  output logic        MUL_SelHL,
  output logic [31:0] MUL_DA,
  output logic [31:0] MUL_DB,
  input  logic        MUL_Flag,
  input  logic [31:0] MUL_DC
);

  localparam int c_CW = $clog2(TMO + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_READ = 2'd2;

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;

  logic w_muldiv;
  logic w_hilo;
  logic w_divzero;

  assign w_muldiv  = !Op_Code[2];
  assign w_hilo    = (Op_Code[2:1] == 2'b10);
  assign w_divzero = w_muldiv && Op_Code[1] && (Op_B == 32'd0);

  assign Op_Ready = (r_state == c_IDLE);
  assign Stall    = Op_Valid && !Op_Ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      MUL_Start  <= 1'b0;
      MUL_SelMD  <= 1'b0;
      MUL_Sign   <= 1'b0;
      MUL_SelHL  <= 1'b0;
      MUL_DA     <= 32'd0;
      MUL_DB     <= 32'd0;
      Rd_Valid   <= 1'b0;
      Rd_Data    <= 32'd0;
      DivZero    <= 1'b0;
      TimeoutErr <= 1'b0;
    end else begin
      MUL_Start <= 1'b0;
      Rd_Valid  <= 1'b0;
      case (r_state)
        c_IDLE: begin
          // Illegal opcodes fall through both branches and are simply dropped.
          if (Op_Valid) begin
            if (w_muldiv) begin
              if (w_divzero) begin
                DivZero <= 1'b1;
              end else begin
                MUL_DA    <= Op_A;
                MUL_DB    <= Op_B;
                MUL_SelMD <= Op_Code[1];
                MUL_Sign  <= !Op_Code[0];
                MUL_Start <= 1'b1;
                r_cnt     <= '0;
                r_state   <= c_WAIT;
              end
            end else if (w_hilo) begin
              MUL_SelHL <= !Op_Code[0];
              r_state   <= c_READ;
            end
          end
        end
        c_WAIT: begin
          if (MUL_Flag) begin
            r_state <= c_IDLE;
          end else if (r_cnt == c_CW'(TMO - 1)) begin
            TimeoutErr <= 1'b1;
            r_state    <= c_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_READ: begin
          // MUL_SelHL has been stable for a full cycle, so MUL_DC is settled.
          Rd_Data  <= MUL_DC;
          Rd_Valid <= 1'b1;
          r_state  <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
